// File: rtl/trng_out_packer.sv
// TRNG output stage: drops a warm-up run of bits after each RUN entry, packs the
// serial stream MSB-first into words and queues them in a small FIFO with overflow accounting.
module trng_out_packer #(
    parameter int WORD_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int DISCARD_BITS = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             output_en,
    input  logic                             rnd_bit,
    output logic [WORD_W-1:0]                out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow,
    output logic [15:0]                      drop_cnt,
    input  logic                             clr_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(WORD_W);
    localparam int DW = (DISCARD_BITS > 1) ? $clog2(DISCARD_BITS) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD_BITS > 0) ? DISCARD_BITS - 1 : 0);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        PACK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       disc_cnt_q, disc_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic                push_req;
    logic [WORD_W-1:0]   push_word;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // ------------------------------------------------------------------
    // Warm-up / packing sequencer
    // ------------------------------------------------------------------
    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        disc_cnt_d = disc_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        push_req   = 1'b0;
        push_word  = {sh_q[WORD_W-2:0], rnd_bit};

        case (state_q)
            IDLE: begin
                // The entry edge only arms the sequencer; its bit is never used.
                if (output_en) begin
                    disc_cnt_d = '0;
                    bit_cnt_d  = '0;
                    sh_d       = '0;
                    state_d    = (DISCARD_BITS == 0) ? PACK : WARMUP;
                end
            end
            WARMUP: begin
                if (!output_en) begin
                    state_d    = IDLE;
                    disc_cnt_d = '0;
                end else if (disc_cnt_q == DISC_LAST) begin
                    state_d    = PACK;
                    disc_cnt_d = '0;
                end else begin
                    disc_cnt_d = disc_cnt_q + DW'(1);
                end
            end
            PACK: begin
                if (!output_en) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    sh_d      = '0;
                end else begin
                    sh_d = push_word;
                    if (bit_cnt_q == BIT_LAST) begin
                        push_req  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            disc_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
        end else begin
            state_q    <= state_d;
            disc_cnt_q <= disc_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO and overflow accounting
    // ------------------------------------------------------------------
    assign full    = (level_q == LVL_FULL);
    assign pop     = out_valid & out_ready;
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop on the same edge as a clear wins and restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage is deliberately left unreset; out_data is masked while the
    // FIFO is empty, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
